// File: rtl/noc_boundary_injector_pkg.sv
// rtl/noc_boundary_injector_pkg.sv - header field layout, FSM states and header packing for the boundary injector
package noc_boundary_injector_pkg;

    localparam int HDR_W         = 64;
    localparam int CHIPID_LSB    = 50;
    localparam int CHIPID_W      = 14;
    localparam int X_LSB         = 42;
    localparam int X_W           = 8;
    localparam int Y_LSB         = 34;
    localparam int Y_W           = 8;
    localparam int FBITS_LSB     = 30;
    localparam int FBITS_W       = 4;
    localparam int LEN_LSB       = 22;
    localparam int LEN_W         = 8;
    localparam int TYPE_LSB      = 14;
    localparam int TYPE_W        = 8;
    localparam int MSHR_LSB      = 6;
    localparam int MSHR_W        = 8;
    localparam int OPT_LSB       = 0;
    localparam int OPT_W         = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_BODY = 2'd2
    } inj_state_e;

    // Field order from MSB down matches the LSB offsets above.
    function automatic logic [HDR_W-1:0] pack_header(
        input logic [CHIPID_W-1:0] chipid,
        input logic [X_W-1:0]      x,
        input logic [Y_W-1:0]      y,
        input logic [FBITS_W-1:0]  fbits,
        input logic [LEN_W-1:0]    len,
        input logic [TYPE_W-1:0]   mtype,
        input logic [MSHR_W-1:0]   mshr,
        input logic [OPT_W-1:0]    opt
    );
        return {chipid, x, y, fbits, len, mtype, mshr, opt};
    endfunction

endpackage

// File: rtl/noc_boundary_injector_credit.sv
// rtl/noc_boundary_injector_credit.sv - downstream credit counter with sticky overflow flag
module noc_credit_counter #(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic consume,
    input  logic yummy,
    output logic has_credit,
    output logic overflow
);

    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0] count_q;

    assign has_credit = (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= CW'(CREDITS);
            overflow <= 1'b0;
        end else begin
            case ({consume, yummy})
                2'b10: count_q <= count_q - CW'(1);
                2'b01: begin
                    // A surplus credit means the router and injector disagree; saturate and flag.
                    if (count_q == CW'(CREDITS)) overflow <= 1'b1;
                    else                         count_q  <= count_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/noc_boundary_injector.sv
// rtl/noc_boundary_injector.sv - serialises header + payload packets onto a credit-flow NoC port
module noc_boundary_injector
    import noc_boundary_injector_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int CREDITS = 4,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [13:0]       cmd_chipid,
    input  logic [7:0]        cmd_x,
    input  logic [7:0]        cmd_y,
    input  logic [3:0]        cmd_fbits,
    input  logic [7:0]        cmd_len,
    input  logic [7:0]        cmd_type,
    input  logic [7:0]        cmd_mshr,
    input  logic [5:0]        cmd_opt,
    input  logic              pld_valid,
    output logic              pld_ready,
    input  logic [DATA_W-1:0] pld_data,
    output logic              noc_valid_out,
    output logic [DATA_W-1:0] noc_data_out,
    input  logic              noc_yummy_in,
    output logic              busy,
    output logic [CNT_W-1:0]  pkt_count,
    output logic              credit_err
);

    inj_state_e        state_q, state_d;
    logic [DATA_W-1:0] hdr_q;
    logic [7:0]        remaining_q;
    logic              has_credit;
    logic              send;
    logic [DATA_W-1:0] send_data;
    logic              pld_fire;
    logic              pkt_inc;

    noc_credit_counter #(.CREDITS(CREDITS)) u_credit (
        .clk        (clk),
        .rst        (rst),
        .consume    (send),
        .yummy      (noc_yummy_in),
        .has_credit (has_credit),
        .overflow   (credit_err)
    );

    assign cmd_ready = (state_q == ST_IDLE);
    assign pld_ready = (state_q == ST_BODY) && has_credit;
    assign busy      = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        send      = 1'b0;
        send_data = pld_data;
        pld_fire  = 1'b0;
        pkt_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (has_credit) begin
                    send      = 1'b1;
                    send_data = hdr_q;
                    if (remaining_q == 8'd0) begin
                        state_d = ST_IDLE;
                        pkt_inc = 1'b1;
                    end else begin
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (pld_valid && has_credit) begin
                    pld_fire = 1'b1;
                    send     = 1'b1;
                    if (remaining_q == 8'd1) begin
                        state_d = ST_IDLE;
                        pkt_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            hdr_q         <= '0;
            remaining_q   <= '0;
            noc_valid_out <= 1'b0;
            noc_data_out  <= '0;
            pkt_count     <= '0;
        end else begin
            state_q       <= state_d;
            noc_valid_out <= send;
            if (send) noc_data_out <= send_data;
            if ((state_q == ST_IDLE) && cmd_valid) begin
                hdr_q       <= DATA_W'(pack_header(cmd_chipid, cmd_x, cmd_y, cmd_fbits,
                                                   cmd_len, cmd_type, cmd_mshr, cmd_opt));
                remaining_q <= cmd_len;
            end else if (pld_fire) begin
                remaining_q <= remaining_q - 8'd1;
            end
            if (pkt_inc) pkt_count <= pkt_count + CNT_W'(1);
        end
    end

endmodule
